// File: rtl/custom_exec_unit_if.sv
// Request/response bundle between the decode stage and the custom execution unit.
// The master side is the upstream pipeline; the slave side is the unit itself.
interface custom_exec_unit_if #(
    parameter int DATA_W = 19,
    parameter int RD_W   = 5
);
    logic              req_valid_i;
    logic              req_ready_o;
    logic [2:0]        custom_instr_i;
    logic [DATA_W-1:0] op1_i;
    logic [DATA_W-1:0] op2_i;
    logic [RD_W-1:0]   rd_i;
    logic              flush_i;
    logic              res_valid_o;
    logic [DATA_W-1:0] res_o;
    logic [DATA_W-1:0] res2_o;
    logic [RD_W-1:0]   res_rd_o;
    logic              illegal_o;
    logic              busy_o;

    modport master (
        output req_valid_i, custom_instr_i, op1_i, op2_i, rd_i, flush_i,
        input  req_ready_o, res_valid_o, res_o, res2_o, res_rd_o, illegal_o, busy_o
    );

    modport slave (
        input  req_valid_i, custom_instr_i, op1_i, op2_i, rd_i, flush_i,
        output req_ready_o, res_valid_o, res_o, res2_o, res_rd_o, illegal_o, busy_o
    );
endinterface

// File: rtl/custom_exec_unit.sv
// Multi-cycle custom coprocessor: iterative rotate/XOR cipher (ENCRYPT/DECRYPT)
// and a 2-point FFT butterfly, with a one-cycle result pulse and pipeline stall.
module custom_exec_unit #(
    parameter int DATA_W = 19,
    parameter int RD_W   = 5,
    parameter int ROUNDS = 4,
    parameter int ROT    = 3
) (
    input  logic               clk,
    input  logic               rst_n,
    custom_exec_unit_if.slave  bus
);
    localparam int CNT_W = $clog2(ROUNDS) + 1;
    localparam logic [CNT_W-1:0] LAST_RND = CNT_W'(ROUNDS - 1);

    localparam logic [2:0] CODE_DATA_MEM = 3'b000;
    localparam logic [2:0] CODE_FFT      = 3'b010;
    localparam logic [2:0] CODE_ENCRYPT  = 3'b101;
    localparam logic [2:0] CODE_DECRYPT  = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    function automatic logic [DATA_W-1:0] rotl_c(input logic [DATA_W-1:0] x);
        return (x << ROT) | (x >> (DATA_W - ROT));
    endfunction

    function automatic logic [DATA_W-1:0] rotr_c(input logic [DATA_W-1:0] x);
        return (x >> ROT) | (x << (DATA_W - ROT));
    endfunction

    function automatic logic [DATA_W-1:0] rotl_v(input logic [DATA_W-1:0] x,
                                                 input logic [CNT_W-1:0]  n);
        logic [2*DATA_W-1:0] t;
        int sh;
        sh = int'(n) % DATA_W;
        t  = {x, x} << sh;
        return t[2*DATA_W-1:DATA_W];
    endfunction

    state_t            state_q, state_d;
    logic [DATA_W-1:0] s_q, s_d;
    logic [DATA_W-1:0] key_q, key_d;
    logic              dec_q, dec_d;
    logic [CNT_W-1:0]  rnd_q, rnd_d;
    logic [RD_W-1:0]   rd_q, rd_d;
    logic [DATA_W-1:0] res_q, res_d;
    logic [DATA_W-1:0] res2_q, res2_d;
    logic [RD_W-1:0]   res_rd_q, res_rd_d;
    logic              illegal_q, illegal_d;

    logic [CNT_W-1:0]  round_idx;
    logic [DATA_W-1:0] round_key;
    logic [DATA_W-1:0] s_next;

    always_comb begin
        state_d   = state_q;
        s_d       = s_q;
        key_d     = key_q;
        dec_d     = dec_q;
        rnd_d     = rnd_q;
        rd_d      = rd_q;
        res_d     = res_q;
        res2_d    = res2_q;
        res_rd_d  = res_rd_q;
        illegal_d = 1'b0;

        // Decryption walks the key schedule backwards so it undoes encryption round by round.
        round_idx = dec_q ? (LAST_RND - rnd_q) : rnd_q;
        round_key = rotl_v(key_q, round_idx);
        s_next    = dec_q ? (rotr_c(s_q) ^ round_key) : rotl_c(s_q ^ round_key);

        if (bus.flush_i) begin
            state_d = ST_IDLE;
            rnd_d   = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (bus.req_valid_i) begin
                        case (bus.custom_instr_i)
                            CODE_DATA_MEM: ;
                            CODE_FFT: begin
                                res_d    = bus.op1_i + bus.op2_i;
                                res2_d   = bus.op1_i - bus.op2_i;
                                res_rd_d = bus.rd_i;
                                state_d  = ST_DONE;
                            end
                            CODE_ENCRYPT, CODE_DECRYPT: begin
                                s_d     = bus.op1_i;
                                key_d   = bus.op2_i;
                                dec_d   = (bus.custom_instr_i == CODE_DECRYPT);
                                rd_d    = bus.rd_i;
                                rnd_d   = '0;
                                state_d = ST_RUN;
                            end
                            default: illegal_d = 1'b1;
                        endcase
                    end
                end
                ST_RUN: begin
                    s_d = s_next;
                    if (rnd_q == LAST_RND) begin
                        res_d    = s_next;
                        res2_d   = '0;
                        res_rd_d = rd_q;
                        rnd_d    = '0;
                        state_d  = ST_DONE;
                    end else begin
                        rnd_d = rnd_q + 1'b1;
                    end
                end
                ST_DONE: state_d = ST_IDLE;
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            s_q       <= '0;
            key_q     <= '0;
            dec_q     <= 1'b0;
            rnd_q     <= '0;
            rd_q      <= '0;
            res_q     <= '0;
            res2_q    <= '0;
            res_rd_q  <= '0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            s_q       <= s_d;
            key_q     <= key_d;
            dec_q     <= dec_d;
            rnd_q     <= rnd_d;
            rd_q      <= rd_d;
            res_q     <= res_d;
            res2_q    <= res2_d;
            res_rd_q  <= res_rd_d;
            illegal_q <= illegal_d;
        end
    end

    // The result pulse is tied to DONE so a flush arriving in DONE cannot hide it.
    assign bus.req_ready_o = (state_q == ST_IDLE);
    assign bus.busy_o      = (state_q != ST_IDLE);
    assign bus.res_valid_o = (state_q == ST_DONE);
    assign bus.res_o       = res_q;
    assign bus.res2_o      = res2_q;
    assign bus.res_rd_o    = res_rd_q;
    assign bus.illegal_o   = illegal_q;
endmodule

// File: tb/tb_custom_exec_unit.sv
// Bench for custom_exec_unit: one default-parameter unit and one single-round unit
// share the request side; each vector selects which unit's responses it checks.
module tb_custom_exec_unit;
    localparam int DW = 19;
    localparam int RW = 5;

    localparam logic [2:0] C_MEM = 3'b000;
    localparam logic [2:0] C_FFT = 3'b010;
    localparam logic [2:0] C_ENC = 3'b101;
    localparam logic [2:0] C_DEC = 3'b111;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    logic          req_valid = 1'b0;
    logic [2:0]    code = '0;
    logic [DW-1:0] op1 = '0;
    logic [DW-1:0] op2 = '0;
    logic [RW-1:0] rd = '0;
    logic          flush = 1'b0;
    logic          sel = 1'b0;

    custom_exec_unit_if #(.DATA_W(DW), .RD_W(RW)) bus_a ();
    custom_exec_unit_if #(.DATA_W(DW), .RD_W(RW)) bus_b ();

    assign bus_a.req_valid_i = req_valid;
    assign bus_a.custom_instr_i = code;
    assign bus_a.op1_i = op1;
    assign bus_a.op2_i = op2;
    assign bus_a.rd_i = rd;
    assign bus_a.flush_i = flush;
    assign bus_b.req_valid_i = req_valid;
    assign bus_b.custom_instr_i = code;
    assign bus_b.op1_i = op1;
    assign bus_b.op2_i = op2;
    assign bus_b.rd_i = rd;
    assign bus_b.flush_i = flush;

    custom_exec_unit #(.DATA_W(DW), .RD_W(RW), .ROUNDS(4), .ROT(3)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus_a)
    );
    custom_exec_unit #(.DATA_W(DW), .RD_W(RW), .ROUNDS(1), .ROT(3)) dut1 (
        .clk(clk), .rst_n(rst_n), .bus(bus_b)
    );

    logic          mon_valid, mon_ill, mon_busy, mon_ready;
    logic [DW-1:0] mon_res, mon_res2;
    logic [RW-1:0] mon_rd;
    assign mon_valid = sel ? bus_b.res_valid_o : bus_a.res_valid_o;
    assign mon_ill   = sel ? bus_b.illegal_o   : bus_a.illegal_o;
    assign mon_busy  = sel ? bus_b.busy_o      : bus_a.busy_o;
    assign mon_ready = sel ? bus_b.req_ready_o : bus_a.req_ready_o;
    assign mon_res   = sel ? bus_b.res_o       : bus_a.res_o;
    assign mon_res2  = sel ? bus_b.res2_o      : bus_a.res2_o;
    assign mon_rd    = sel ? bus_b.res_rd_o    : bus_a.res_rd_o;

    typedef struct {
        logic          sel;
        logic [2:0]    code;
        logic [DW-1:0] op1;
        logic [DW-1:0] op2;
        logic [RW-1:0] rd;
        logic          flush;
        int            exp_valid;
        int            exp_lat;
        logic [DW-1:0] exp_res;
        logic [DW-1:0] exp_res2;
        logic [RW-1:0] exp_rd;
        int            exp_ill;
        int            exp_busy;
    } vec_t;

    vec_t vecs[12];
    int n_cmp = 0;
    int n_fail = 0;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Present one request for a single edge, then return sampling in cycle 1.
    task automatic startReq(input logic [2:0] c, input logic [DW-1:0] a, input logic [DW-1:0] b,
                            input logic [RW-1:0] r, input logic f);
        @(negedge clk);
        req_valid = 1'b1;
        code = c;
        op1 = a;
        op2 = b;
        rd = r;
        flush = f;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        code = '0;
        flush = 1'b0;
    endtask

    task automatic countValid(input int cycles, output int vcnt);
        vcnt = 0;
        for (int c = 0; c < cycles; c++) begin
            @(posedge clk);
            #1;
            if (mon_valid) vcnt++;
        end
    endtask

    task automatic applyStimulus(input vec_t v, input string tag);
        int vcnt, lat, icnt, icyc, bcnt, rdybad;
        logic [DW-1:0] pres, pres2;
        logic [RW-1:0] prd;
        vcnt = 0; lat = 0; icnt = 0; icyc = 0; bcnt = 0; rdybad = 0;
        pres = '0; pres2 = '0; prd = '0;
        sel = v.sel;
        startReq(v.code, v.op1, v.op2, v.rd, v.flush);
        for (int c = 1; c <= 8; c++) begin
            if (c > 1) begin
                @(posedge clk);
                #1;
            end
            if (mon_valid) begin
                vcnt++;
                if (vcnt == 1) begin
                    lat = c;
                    pres = mon_res;
                    pres2 = mon_res2;
                    prd = mon_rd;
                end
            end
            if (mon_ill) begin
                icnt++;
                icyc = c;
            end
            if (mon_busy) bcnt++;
            if (mon_ready == mon_busy) rdybad++;
        end
        checkOutput({tag, "_valid_count"}, vcnt, v.exp_valid);
        checkOutput({tag, "_latency"}, lat, v.exp_lat);
        if (v.exp_valid != 0) begin
            checkOutput({tag, "_pulse_res"}, pres, v.exp_res);
            checkOutput({tag, "_pulse_res2"}, pres2, v.exp_res2);
            checkOutput({tag, "_pulse_rd"}, prd, v.exp_rd);
        end
        checkOutput({tag, "_held_res"}, mon_res, v.exp_res);
        checkOutput({tag, "_held_res2"}, mon_res2, v.exp_res2);
        checkOutput({tag, "_held_rd"}, mon_rd, v.exp_rd);
        checkOutput({tag, "_illegal_count"}, icnt, v.exp_ill);
        checkOutput({tag, "_illegal_cycle"}, icyc, v.exp_ill);
        checkOutput({tag, "_busy_cycles"}, bcnt, v.exp_busy);
        checkOutput({tag, "_ready_vs_busy"}, rdybad, 0);
    endtask

    initial begin
        int vc;

        //                sel   code   op1       op2       rd     fl  v  lat res       res2      rd     il busy
        vecs[0]  = '{1'b0, C_FFT, 19'h00005, 19'h00007, 5'h03, 1'b0, 1, 1, 19'h0000C, 19'h7FFFE, 5'h03, 0, 1};
        vecs[1]  = '{1'b1, C_ENC, 19'h00001, 19'h00003, 5'h07, 1'b0, 1, 2, 19'h00010, 19'h00000, 5'h07, 0, 2};
        vecs[2]  = '{1'b1, C_ENC, 19'h40000, 19'h00000, 5'h09, 1'b0, 1, 2, 19'h00004, 19'h00000, 5'h09, 0, 2};
        vecs[3]  = '{1'b1, C_DEC, 19'h00010, 19'h00003, 5'h0A, 1'b0, 1, 2, 19'h00001, 19'h00000, 5'h0A, 0, 2};
        vecs[4]  = '{1'b0, C_ENC, 19'h5A5A5, 19'h1F0F0, 5'h11, 1'b0, 1, 5, 19'h25463, 19'h00000, 5'h11, 0, 5};
        vecs[5]  = '{1'b0, C_DEC, 19'h25463, 19'h1F0F0, 5'h12, 1'b0, 1, 5, 19'h5A5A5, 19'h00000, 5'h12, 0, 5};
        vecs[6]  = '{1'b0, 3'b100, 19'h00123, 19'h00456, 5'h01, 1'b0, 0, 0, 19'h5A5A5, 19'h00000, 5'h12, 1, 0};
        vecs[7]  = '{1'b0, C_MEM, 19'h00123, 19'h00456, 5'h02, 1'b0, 0, 0, 19'h5A5A5, 19'h00000, 5'h12, 0, 0};
        vecs[8]  = '{1'b0, C_FFT, 19'h7FFFF, 19'h00001, 5'h1F, 1'b0, 1, 1, 19'h00000, 19'h7FFFE, 5'h1F, 0, 1};
        vecs[9]  = '{1'b0, 3'b001, 19'h00001, 19'h00001, 5'h04, 1'b0, 0, 0, 19'h00000, 19'h7FFFE, 5'h1F, 1, 0};
        vecs[10] = '{1'b0, 3'b110, 19'h00001, 19'h00001, 5'h05, 1'b0, 0, 0, 19'h00000, 19'h7FFFE, 5'h1F, 1, 0};
        vecs[11] = '{1'b0, C_FFT, 19'h00001, 19'h00001, 5'h06, 1'b1, 0, 0, 19'h00000, 19'h7FFFE, 5'h1F, 0, 0};

        $display("[TB] reset");
        #2 rst_n = 1'b0;
        #10;
        sel = 1'b0;
        checkOutput("rst_ready", mon_ready, 1);
        checkOutput("rst_busy", mon_busy, 0);
        checkOutput("rst_valid", mon_valid, 0);
        checkOutput("rst_res", mon_res, 0);
        checkOutput("rst_res2", mon_res2, 0);
        checkOutput("rst_rd", mon_rd, 0);
        checkOutput("rst_illegal", mon_ill, 0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 12; i++) begin
            applyStimulus(vecs[i], $sformatf("v%0d", i));
        end

        $display("[TB] flush while DONE");
        sel = 1'b0;
        startReq(C_FFT, 19'h00002, 19'h00001, 5'h08, 1'b0);
        checkOutput("fdone_valid", mon_valid, 1);
        checkOutput("fdone_res", mon_res, 19'h00003);
        flush = 1'b1;
        #1;
        checkOutput("fdone_valid_with_flush", mon_valid, 1);
        @(posedge clk);
        #1;
        flush = 1'b0;
        checkOutput("fdone_after_busy", mon_busy, 0);
        checkOutput("fdone_after_valid", mon_valid, 0);
        checkOutput("fdone_after_res2", mon_res2, 19'h00001);

        $display("[TB] flush during RUN");
        startReq(C_ENC, 19'h5A5A5, 19'h1F0F0, 5'h13, 1'b0);
        @(posedge clk);
        #1;
        checkOutput("frun_busy_before", mon_busy, 1);
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        checkOutput("frun_busy", mon_busy, 0);
        checkOutput("frun_ready", mon_ready, 1);
        countValid(8, vc);
        checkOutput("frun_no_valid", vc, 0);
        checkOutput("frun_res_held", mon_res, 19'h00003);
        applyStimulus(vecs[4], "frun_next_enc");

        $display("[TB] async reset during RUN");
        startReq(C_ENC, 19'h00777, 19'h1F0F0, 5'h15, 1'b0);
        @(posedge clk);
        #1;
        checkOutput("arst_busy_before", mon_busy, 1);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("arst_res", mon_res, 0);
        checkOutput("arst_rd", mon_rd, 0);
        checkOutput("arst_busy", mon_busy, 0);
        checkOutput("arst_ready", mon_ready, 1);
        checkOutput("arst_valid", mon_valid, 0);
        @(negedge clk);
        rst_n = 1'b1;
        countValid(8, vc);
        checkOutput("arst_no_late_valid", vc, 0);
        checkOutput("arst_res_still_zero", mon_res, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
